// File: rtl/tdma_slot_tx_gate.sv
// -----------------------------------------------------------------------------
// tdma_slot_tx_gate
//
// Gates an AXI-Stream frame path so that a frame may only start inside a TDMA
// slot owned by this node, and only while at least guard_cycles remain in the
// slot. A frame that has started always completes, even across slot
// boundaries. A slot boundary arriving mid-frame is reported as an overrun.
// The datapath is a zero-latency wire-through with no storage.
//
// Handshake: a beat transfers on a cycle where tvalid and tready are both 1.
//   m_axis_tvalid never depends on m_axis_tready, and s_axis_tready only
//   follows m_axis_tready while the gate is open, so the upstream and
//   downstream handshakes are the same transfer.
//
// Ports
//   ACLK, ARESET        clock, synchronous active-high reset
//   slot_start          1-cycle pulse at each slot boundary
//   slot_idx            slot number, valid with slot_start
//   slot_len            slot length in cycles, sampled on slot_start
//   guard_cycles        minimum cycles remaining to start a frame (used live)
//   own_mask            bit n = this node owns slot n (sampled on slot_start)
//   enable              global enable (sampled on slot_start)
//   s_axis_*            upstream frame stream
//   m_axis_*            downstream frame stream (data/last wired through)
//   overrun             1-cycle pulse: slot boundary arrived mid-frame
//   frames_sent         completed frames, wraps
//   overrun_cnt         overruns, saturates at 0xFFFF
//   dbg_state           current FSM state (0 CLOSED, 1 OPEN, 2 SEND)
// -----------------------------------------------------------------------------
module tdma_slot_tx_gate #(
    parameter int DATA_W    = 32,
    parameter int NUM_SLOTS = 16,
    parameter int SLOT_W    = 4
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 slot_start,
    input  logic [SLOT_W-1:0]    slot_idx,
    input  logic [15:0]          slot_len,
    input  logic [15:0]          guard_cycles,
    input  logic [NUM_SLOTS-1:0] own_mask,
    input  logic                 enable,
    input  logic [DATA_W-1:0]    s_axis_tdata,
    input  logic                 s_axis_tvalid,
    input  logic                 s_axis_tlast,
    output logic                 s_axis_tready,
    output logic [DATA_W-1:0]    m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    input  logic                 m_axis_tready,
    output logic                 overrun,
    output logic [31:0]          frames_sent,
    output logic [15:0]          overrun_cnt,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        ST_CLOSED = 2'd0,
        ST_OPEN   = 2'd1,
        ST_SEND   = 2'd2
    } state_t;

    // own_mask is zero-extended to cover every encodable slot_idx, so slot
    // numbers beyond NUM_SLOTS read as "not owned" without an out-of-range index.
    localparam int MASK_EXT_W = 2 ** SLOT_W;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [15:0]             r_slot_cnt;
    logic                    r_owned;
    logic [31:0]             r_frames_sent;
    logic [15:0]             r_overrun_cnt;

    logic [MASK_EXT_W-1:0]   w_mask_ext;
    logic                    w_new_owned;
    logic                    w_start_ok;
    logic                    w_open;
    logic                    w_beat;
    logic                    w_frame_done;
    logic                    w_overrun;

    assign w_mask_ext  = MASK_EXT_W'(own_mask);
    assign w_new_owned = enable & w_mask_ext[slot_idx];

    // A frame may start only with enough of the owned slot left.
    assign w_start_ok = (r_slot_cnt >= guard_cycles) & (r_slot_cnt != 16'd0) & r_owned;
    assign w_open     = (r_state == ST_SEND) | ((r_state == ST_OPEN) & w_start_ok);

    // Reset forces both handshake outputs low in the same cycle.
    assign m_axis_tvalid = s_axis_tvalid & w_open & ~ARESET;
    assign s_axis_tready = m_axis_tready & w_open & ~ARESET;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tlast  = s_axis_tlast;

    assign w_beat       = s_axis_tvalid & s_axis_tready;
    assign w_frame_done = w_beat & s_axis_tlast;

    // A boundary coinciding with the closing beat is not an overrun: the
    // frame ends in the old slot.
    assign w_overrun = (r_state == ST_SEND) & slot_start & ~w_frame_done & ~ARESET;

    assign overrun     = w_overrun;
    assign frames_sent = r_frames_sent;
    assign overrun_cnt = r_overrun_cnt;
    assign dbg_state   = r_state;

    // Next-state logic; decisions use the registered slot view except where a
    // slot_start in the same cycle hands over to the newly latched slot.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLOSED: begin
                if (slot_start && w_new_owned) begin
                    w_state_nxt = ST_OPEN;
                end
            end
            ST_OPEN: begin
                if (w_beat && !s_axis_tlast) begin
                    w_state_nxt = ST_SEND;
                end else if (slot_start) begin
                    w_state_nxt = w_new_owned ? ST_OPEN : ST_CLOSED;
                end else if (!w_start_ok) begin
                    w_state_nxt = ST_CLOSED;
                end
            end
            ST_SEND: begin
                if (w_frame_done) begin
                    if (slot_start) begin
                        w_state_nxt = w_new_owned ? ST_OPEN : ST_CLOSED;
                    end else begin
                        w_state_nxt = w_start_ok ? ST_OPEN : ST_CLOSED;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_CLOSED;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= ST_CLOSED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Slot tracking: load remaining-cycles count at each boundary, then count
    // down and hold at zero.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_slot_cnt <= 16'd0;
            r_owned    <= 1'b0;
        end else if (slot_start) begin
            r_slot_cnt <= (slot_len == 16'd0) ? 16'd0 : slot_len - 16'd1;
            r_owned    <= w_new_owned;
        end else if (r_slot_cnt != 16'd0) begin
            r_slot_cnt <= r_slot_cnt - 16'd1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_frames_sent <= 32'd0;
            r_overrun_cnt <= 16'd0;
        end else begin
            if (w_frame_done) begin
                r_frames_sent <= r_frames_sent + 32'd1;
            end
            if (w_overrun && (r_overrun_cnt != 16'hFFFF)) begin
                r_overrun_cnt <= r_overrun_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_tdma_slot_tx_gate.sv
// -----------------------------------------------------------------------------
// tb_tdma_slot_tx_gate
//
// Cycle-stepped bench. A frame source on the upstream side pushes every beat
// it hands over into exp_q; the downstream monitor pops and compares each beat
// that leaves the gate. Directed slot sequences check gating, guard timing,
// overrun behaviour, back-pressure and reset.
// -----------------------------------------------------------------------------
module tb_tdma_slot_tx_gate;

    localparam int DATA_W    = 32;
    localparam int NUM_SLOTS = 16;
    localparam int SLOT_W    = 4;

    localparam logic [1:0] CLOSED = 2'd0;
    localparam logic [1:0] SEND   = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 ARESET;
    logic                 slot_start;
    logic [SLOT_W-1:0]    slot_idx;
    logic [15:0]          slot_len;
    logic [15:0]          guard_cycles;
    logic [NUM_SLOTS-1:0] own_mask;
    logic                 enable;
    logic [DATA_W-1:0]    s_axis_tdata;
    logic                 s_axis_tvalid;
    logic                 s_axis_tlast;
    logic                 s_axis_tready;
    logic [DATA_W-1:0]    m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tlast;
    logic                 m_axis_tready;
    logic                 overrun;
    logic [31:0]          frames_sent;
    logic [15:0]          overrun_cnt;
    logic [1:0]           dbg_state;

    tdma_slot_tx_gate #(
        .DATA_W    (DATA_W),
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_W    (SLOT_W)
    ) dut (
        .ACLK          (clk),
        .ARESET        (ARESET),
        .slot_start    (slot_start),
        .slot_idx      (slot_idx),
        .slot_len      (slot_len),
        .guard_cycles  (guard_cycles),
        .own_mask      (own_mask),
        .enable        (enable),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .overrun       (overrun),
        .frames_sent   (frames_sent),
        .overrun_cnt   (overrun_cnt),
        .dbg_state     (dbg_state)
    );

    // ---------------- scoreboard / bookkeeping ----------------
    logic [DATA_W:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    // source state
    logic        src_on    = 1'b0;
    int          frame_len = 4;
    int          beat_i    = 0;
    logic [31:0] data_ctr  = 32'h1000;

    int beats   = 0;
    int ov_seen = 0;

    // values sampled at the falling edge of the last stepped cycle
    logic        smp_tready;
    logic        smp_mvalid;
    logic        smp_overrun;
    logic        smp_hs_last;
    logic [1:0]  smp_state;
    logic [31:0] smp_frames;
    logic [15:0] smp_ovcnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver / monitor ----------------
    // One clock cycle: drive the source, sample at the falling edge, then
    // advance the source past the rising edge.
    task automatic tick();
        logic            hs;
        logic [DATA_W:0] item;
        s_axis_tvalid = src_on;
        s_axis_tdata  = data_ctr;
        s_axis_tlast  = (beat_i == frame_len - 1);
        @(negedge clk);
        smp_tready  = s_axis_tready;
        smp_mvalid  = m_axis_tvalid;
        smp_overrun = overrun;
        smp_state   = dbg_state;
        smp_frames  = frames_sent;
        smp_ovcnt   = overrun_cnt;
        hs          = s_axis_tvalid & s_axis_tready;
        smp_hs_last = hs & (beat_i == frame_len - 1);
        if (hs) begin
            exp_q.push_back({(beat_i == frame_len - 1), data_ctr});
            beats++;
        end
        if (overrun) ov_seen++;
        if (m_axis_tvalid && m_axis_tready) begin
            chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                item = exp_q.pop_front();
                chk("sb_beat", 64'({m_axis_tlast, m_axis_tdata}), 64'(item));
            end
        end
        @(posedge clk);
        #1;
        if (hs) begin
            data_ctr = data_ctr + 32'd1;
            beat_i   = (beat_i == frame_len - 1) ? 0 : beat_i + 1;
        end
    endtask

    task automatic slot_pulse(input int idx, input int len);
        slot_start = 1'b1;
        slot_idx   = SLOT_W'(idx);
        slot_len   = 16'(len);
        tick();
        slot_start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int b;
        int ov0;
        logic [31:0] f0;

        ARESET        = 1'b1;
        slot_start    = 1'b0;
        slot_idx      = '0;
        slot_len      = 16'd0;
        guard_cycles  = 16'd10;
        own_mask      = 16'h0002;
        enable        = 1'b1;
        m_axis_tready = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        src_on        = 1'b1;
        frame_len     = 4;

        // reset state
        tick();
        tick();
        chk("rst_tready", 64'(smp_tready), 64'd0);
        chk("rst_mvalid", 64'(smp_mvalid), 64'd0);
        chk("rst_overrun", 64'(smp_overrun), 64'd0);
        ARESET = 1'b0;
        tick();
        chk("rst_state", 64'(smp_state), 64'(CLOSED));
        chk("rst_frames", 64'(smp_frames), 64'd0);
        chk("rst_ovcnt", 64'(smp_ovcnt), 64'd0);
        chk("rst_closed_tready", 64'(smp_tready), 64'd0);

        // 1: slots 0,1,2; only slot 1 owned, 4-beat frames always offered
        b = beats;
        slot_pulse(0, 100);
        repeat (99) tick();
        chk("t1_slot0_beats", 64'(beats - b), 64'd0);
        b = beats;
        slot_pulse(1, 100);
        repeat (99) tick();
        chk("t1_slot1_beats", 64'(beats - b), 64'd92);
        b = beats;
        slot_pulse(2, 100);
        repeat (99) tick();
        chk("t1_slot2_beats", 64'(beats - b), 64'd0);
        chk("t1_frames", 64'(smp_frames), 64'd23);

        // 2: frame offered at slot_cnt=9 is refused, at slot_cnt=10 accepted
        src_on = 1'b0;
        slot_pulse(1, 100);
        for (int k = 1; k <= 99; k++) begin
            if (k == 91) src_on = 1'b1;
            if (k == 92) src_on = 1'b0;
            tick();
            if (k == 91) chk("t2_tready_cnt9", 64'(smp_tready), 64'd0);
            if (k == 92) chk("t2_state_closed", 64'(smp_state), 64'(CLOSED));
        end
        slot_pulse(1, 100);
        for (int k = 1; k <= 99; k++) begin
            if (k == 90) src_on = 1'b1;
            if (k == 94) src_on = 1'b0;
            tick();
            if (k == 90) chk("t2_tready_cnt10", 64'(smp_tready), 64'd1);
            if (k == 91) chk("t2_state_send", 64'(smp_state), 64'(SEND));
        end
        chk("t2_frames", 64'(smp_frames), 64'd24);

        // 3: 200-beat frame starting at slot_cnt=50 runs across the boundary
        ov0 = ov_seen;
        slot_pulse(1, 100);
        for (int k = 1; k <= 99; k++) begin
            if (k == 50) begin
                frame_len = 200;
                src_on    = 1'b1;
            end
            tick();
        end
        slot_pulse(2, 200);
        chk("t3_overrun_pulse", 64'(smp_overrun), 64'd1);
        for (int k = 101; k <= 255; k++) begin
            if (k == 250) src_on = 1'b0;
            tick();
            if (k == 249) chk("t3_tlast_at_249", 64'(smp_hs_last), 64'd1);
            if (k == 250) chk("t3_state_closed", 64'(smp_state), 64'(CLOSED));
        end
        frame_len = 4;
        chk("t3_overrun_once", 64'(ov_seen - ov0), 64'd1);
        chk("t3_overrun_cnt", 64'(smp_ovcnt), 64'd1);
        chk("t3_frames", 64'(smp_frames), 64'd25);

        // 4: tlast beat coincides with slot_start -> no overrun
        guard_cycles = 16'd0;
        slot_pulse(1, 8);
        src_on = 1'b1;
        repeat (7) tick();
        slot_pulse(2, 100);
        chk("t4_tlast_on_boundary", 64'(smp_hs_last), 64'd1);
        chk("t4_no_overrun", 64'(smp_overrun), 64'd0);
        src_on = 1'b0;
        tick();
        chk("t4_state_closed", 64'(smp_state), 64'(CLOSED));
        chk("t4_ovcnt_same", 64'(smp_ovcnt), 64'd1);
        chk("t4_frames", 64'(smp_frames), 64'd27);
        guard_cycles = 16'd10;

        // 5: downstream back-pressure toggling 1010
        f0 = smp_frames;
        slot_pulse(1, 100);
        b = beats;
        src_on = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            m_axis_tready = (k % 2 == 1);
            tick();
        end
        src_on        = 1'b0;
        m_axis_tready = 1'b1;
        chk("t5_beats", 64'(beats - b), 64'd20);
        chk("t5_frames", 64'(smp_frames - f0), 64'd5);

        // 6: reset mid-frame
        slot_pulse(1, 100);
        src_on = 1'b1;
        repeat (5) tick();
        ARESET = 1'b1;
        tick();
        chk("t6_rst_tready", 64'(smp_tready), 64'd0);
        chk("t6_rst_mvalid", 64'(smp_mvalid), 64'd0);
        tick();
        ARESET = 1'b0;
        beat_i = 0;
        exp_q.delete();
        tick();
        chk("t6_state", 64'(smp_state), 64'(CLOSED));
        chk("t6_frames", 64'(smp_frames), 64'd0);
        chk("t6_ovcnt", 64'(smp_ovcnt), 64'd0);
        b = beats;
        repeat (20) tick();
        chk("t6_blocked_beats", 64'(beats - b), 64'd0);
        slot_pulse(1, 100);
        b = beats;
        repeat (10) tick();
        chk("t6_resume_beats", 64'(beats - b), 64'd10);
        chk("t6_resume_frames", 64'(smp_frames), 64'd2);
        src_on = 1'b0;
        repeat (2) tick();

        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
